// File: rtl/cm_event_sink.sv
// Receiving end of the CM output interface: turns valid pulses and status changes
// into tagged events, buffers them in a show-ahead FIFO, and keeps error/drop statistics.
module cm_event_sink #(
  parameter int CONFIG_STATUS_WIDTH       = 4,
  parameter int CONFIG_NOTIFICATION_WIDTH = 4,
  parameter int CONFIG_ERROR_WIDTH        = 4,
  parameter int VGA_NOTIFICATION_WIDTH    = 4,
  parameter int DATA_WIDTH                = 8,
  parameter int FIFO_DEPTH                = 8,
  localparam int CODE_W01 = (CONFIG_STATUS_WIDTH > CONFIG_NOTIFICATION_WIDTH) ?
                            CONFIG_STATUS_WIDTH : CONFIG_NOTIFICATION_WIDTH,
  localparam int CODE_W23 = (CONFIG_ERROR_WIDTH > VGA_NOTIFICATION_WIDTH) ?
                            CONFIG_ERROR_WIDTH : VGA_NOTIFICATION_WIDTH,
  localparam int CODE_W   = (CODE_W01 > CODE_W23) ? CODE_W01 : CODE_W23
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [CONFIG_STATUS_WIDTH-1:0]       Config_Status,
  input  logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification,
  input  logic                                 Config_Notification_Valid,
  input  logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error,
  input  logic                                 Error_Valid,
  input  logic [VGA_NOTIFICATION_WIDTH-1:0]    VGA_Notification,
  input  logic                                 VGA_Notification_Valid,
  input  logic [DATA_WIDTH-1:0]                Data_VGA,
  output logic                                 Evt_Valid,
  input  logic                                 Evt_Ready,
  output logic [1:0]                           Evt_Tag,
  output logic [CODE_W-1:0]                    Evt_Code,
  output logic [DATA_WIDTH-1:0]                Evt_Data,
  input  logic                                 Clr,
  output logic [7:0]                           Error_Count,
  output logic [7:0]                           Drop_Count,
  output logic                                 Overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 2 + CODE_W + DATA_WIDTH;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  // Slot index doubles as the event tag: 0=ERR, 1=CFG, 2=VGA, 3=STS.
  logic [3:0]                     r_slot_vld;
  logic [CODE_W-1:0]              r_slot_code [4];
  logic [DATA_WIDTH-1:0]          r_slot_data [4];
  logic [CONFIG_STATUS_WIDTH-1:0] r_prev_status;
  logic [ENT_W-1:0]               r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]               r_wptr;
  logic [PTR_W-1:0]               r_rptr;
  logic [PTR_W:0]                 r_count;
  logic [7:0]                     r_err_cnt;
  logic [7:0]                     r_drop_cnt;
  logic                           r_ovf;

  logic [3:0]            w_arr;
  logic [CODE_W-1:0]     w_new_code [4];
  logic [DATA_WIDTH-1:0] w_new_data [4];
  logic [1:0]            w_sel;
  logic                  w_any;
  logic                  w_valid;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic [3:0]            w_pushed;
  logic [3:0]            w_load;
  logic [3:0]            w_drop;
  logic [2:0]            w_drop_n;
  logic [7:0]            w_err_base;
  logic [7:0]            w_drop_base;
  logic [8:0]            w_drop_sum;
  logic [7:0]            w_err_next;
  logic [7:0]            w_drop_next;
  logic [ENT_W-1:0]      w_head;

  // Candidate event fields per source and arrival detection.
  always_comb begin
    w_new_code[0] = CODE_W'(Config_Error);
    w_new_code[1] = CODE_W'(Config_Notification);
    w_new_code[2] = CODE_W'(VGA_Notification);
    w_new_code[3] = CODE_W'(Config_Status);
    w_new_data[0] = DATA_WIDTH'(Config_Status);
    w_new_data[1] = DATA_WIDTH'(Config_Status);
    w_new_data[2] = Data_VGA;
    w_new_data[3] = DATA_WIDTH'(Config_Status);
    w_arr = {(Config_Status != r_prev_status), VGA_Notification_Valid,
             Config_Notification_Valid, Error_Valid};
  end

  // Fixed-priority slot selection and push/pop/drop decisions.
  always_comb begin
    w_any = 1'b1;
    if (r_slot_vld[0]) begin
      w_sel = 2'd0;
    end else if (r_slot_vld[1]) begin
      w_sel = 2'd1;
    end else if (r_slot_vld[2]) begin
      w_sel = 2'd2;
    end else if (r_slot_vld[3]) begin
      w_sel = 2'd3;
    end else begin
      w_sel = 2'd0;
      w_any = 1'b0;
    end
    w_valid  = (r_count != {(PTR_W+1){1'b0}});
    w_full   = (r_count == DEPTH_C);
    w_pop    = w_valid && Evt_Ready;
    w_push   = w_any && (!w_full || w_pop);
    w_drop_n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      w_pushed[i] = w_push && (w_sel == 2'(i));
      w_load[i]   = w_arr[i] && (!r_slot_vld[i] || w_pushed[i]);
      w_drop[i]   = w_arr[i] && r_slot_vld[i] && !w_pushed[i];
      w_drop_n    = w_drop_n + {2'd0, w_drop[i]};
    end
  end

  // Next values of the saturating statistics; Clr zeroes the base, not the increment.
  always_comb begin
    w_err_base  = Clr ? 8'd0 : r_err_cnt;
    w_drop_base = Clr ? 8'd0 : r_drop_cnt;
    if (Error_Valid && (w_err_base != 8'hFF)) begin
      w_err_next = w_err_base + 8'd1;
    end else begin
      w_err_next = w_err_base;
    end
    w_drop_sum = {1'b0, w_drop_base} + {6'd0, w_drop_n};
    if (w_drop_sum > 9'd255) begin
      w_drop_next = 8'hFF;
    end else begin
      w_drop_next = w_drop_sum[7:0];
    end
  end

  // Pending slots and previous-status tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_vld    <= 4'd0;
      r_prev_status <= {CONFIG_STATUS_WIDTH{1'b0}};
      for (int i = 0; i < 4; i++) begin
        r_slot_code[i] <= {CODE_W{1'b0}};
        r_slot_data[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      r_prev_status <= Config_Status;
      for (int i = 0; i < 4; i++) begin
        if (w_load[i]) begin
          r_slot_vld[i]  <= 1'b1;
          r_slot_code[i] <= w_new_code[i];
          r_slot_data[i] <= w_new_data[i];
        end else if (w_pushed[i]) begin
          r_slot_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Event FIFO storage and pointers; power-of-2 depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= {ENT_W{1'b0}};
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {w_sel, r_slot_code[w_sel], r_slot_data[w_sel]};
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating counters and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt  <= 8'd0;
      r_drop_cnt <= 8'd0;
      r_ovf      <= 1'b0;
    end else begin
      r_err_cnt  <= w_err_next;
      r_drop_cnt <= w_drop_next;
      r_ovf      <= (r_ovf && !Clr) || (|w_drop);
    end
  end

  // Head presentation, forced to zero while the FIFO is empty.
  always_comb begin
    w_head    = r_mem[r_rptr];
    Evt_Valid = w_valid;
    if (w_valid) begin
      Evt_Tag  = w_head[ENT_W-1 -: 2];
      Evt_Code = w_head[DATA_WIDTH +: CODE_W];
      Evt_Data = w_head[DATA_WIDTH-1:0];
    end else begin
      Evt_Tag  = 2'd0;
      Evt_Code = {CODE_W{1'b0}};
      Evt_Data = {DATA_WIDTH{1'b0}};
    end
  end

  assign Error_Count = r_err_cnt;
  assign Drop_Count  = r_drop_cnt;
  assign Overflow    = r_ovf;

endmodule

// File: tb/tb_cm_event_sink.sv
// Directed self-checking bench for cm_event_sink using immediate assertions.
module tb_cm_event_sink;

  logic       clk;
  logic       rst_n;
  logic [3:0] Config_Status;
  logic [3:0] Config_Notification;
  logic       Config_Notification_Valid;
  logic [3:0] Config_Error;
  logic       Error_Valid;
  logic [3:0] VGA_Notification;
  logic       VGA_Notification_Valid;
  logic [7:0] Data_VGA;
  logic       Evt_Valid;
  logic       Evt_Ready;
  logic [1:0] Evt_Tag;
  logic [3:0] Evt_Code;
  logic [7:0] Evt_Data;
  logic       Clr;
  logic [7:0] Error_Count;
  logic [7:0] Drop_Count;
  logic       Overflow;

  int n_checks = 0;
  int n_err    = 0;

  cm_event_sink dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .Config_Status             (Config_Status),
    .Config_Notification       (Config_Notification),
    .Config_Notification_Valid (Config_Notification_Valid),
    .Config_Error              (Config_Error),
    .Error_Valid               (Error_Valid),
    .VGA_Notification          (VGA_Notification),
    .VGA_Notification_Valid    (VGA_Notification_Valid),
    .Data_VGA                  (Data_VGA),
    .Evt_Valid                 (Evt_Valid),
    .Evt_Ready                 (Evt_Ready),
    .Evt_Tag                   (Evt_Tag),
    .Evt_Code                  (Evt_Code),
    .Evt_Data                  (Evt_Data),
    .Clr                       (Clr),
    .Error_Count               (Error_Count),
    .Drop_Count                (Drop_Count),
    .Overflow                  (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input logic [1:0] t, input logic [3:0] c,
                         input logic [7:0] d);
    chk({tag, "_valid"}, {31'd0, Evt_Valid}, 32'd1);
    chk({tag, "_tag"},   {30'd0, Evt_Tag},   {30'd0, t});
    chk({tag, "_code"},  {28'd0, Evt_Code},  {28'd0, c});
    chk({tag, "_data"},  {24'd0, Evt_Data},  {24'd0, d});
  endtask

  initial begin
    rst_n = 1'b0;
    Config_Status = 4'h0;
    Config_Notification = 4'h0;
    Config_Notification_Valid = 1'b0;
    Config_Error = 4'h0;
    Error_Valid = 1'b0;
    VGA_Notification = 4'h0;
    VGA_Notification_Valid = 1'b0;
    Data_VGA = 8'h00;
    Evt_Ready = 1'b1;
    Clr = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, Evt_Valid}, 32'd0);
    chk("rst_tag",   {30'd0, Evt_Tag},   32'd0);
    chk("rst_code",  {28'd0, Evt_Code},  32'd0);
    chk("rst_data",  {24'd0, Evt_Data},  32'd0);
    chk("rst_errc",  {24'd0, Error_Count}, 32'd0);
    chk("rst_dropc", {24'd0, Drop_Count},  32'd0);
    chk("rst_ovf",   {31'd0, Overflow},    32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Single VGA event: visible two edges after sampling, for one cycle.
    VGA_Notification = 4'h5;
    Data_VGA = 8'hA3;
    VGA_Notification_Valid = 1'b1;
    tick();
    VGA_Notification_Valid = 1'b0;
    chk("vga_lat1", {31'd0, Evt_Valid}, 32'd0);
    tick();
    chk_evt("vga", 2'd2, 4'h5, 8'hA3);
    tick();
    chk("vga_gone", {31'd0, Evt_Valid}, 32'd0);

    // Four simultaneous sources drain in priority order.
    Config_Error = 4'h3;
    Error_Valid = 1'b1;
    Config_Notification = 4'h9;
    Config_Notification_Valid = 1'b1;
    VGA_Notification = 4'h1;
    Data_VGA = 8'h5C;
    VGA_Notification_Valid = 1'b1;
    Config_Status = 4'h2;
    tick();
    Error_Valid = 1'b0;
    Config_Notification_Valid = 1'b0;
    VGA_Notification_Valid = 1'b0;
    tick();
    chk_evt("sim0", 2'd0, 4'h3, 8'h02);
    tick();
    chk_evt("sim1", 2'd1, 4'h9, 8'h02);
    tick();
    chk_evt("sim2", 2'd2, 4'h1, 8'h5C);
    tick();
    chk_evt("sim3", 2'd3, 4'h2, 8'h02);
    tick();
    chk("sim_empty", {31'd0, Evt_Valid}, 32'd0);
    chk("sim_errc",  {24'd0, Error_Count}, 32'd1);
    chk("sim_dropc", {24'd0, Drop_Count},  32'd0);

    // Backpressure: 8 fill the FIFO, 9th waits in the slot, 10th is dropped.
    Evt_Ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      Config_Notification = 4'(i);
      Config_Notification_Valid = 1'b1;
      tick();
      Config_Notification_Valid = 1'b0;
      tick();
    end
    chk("bp_dropc", {24'd0, Drop_Count}, 32'd1);
    chk("bp_ovf",   {31'd0, Overflow},   32'd1);
    chk_evt("bp_hold", 2'd1, 4'h1, 8'h02);
    tick();
    chk_evt("bp_stable", 2'd1, 4'h1, 8'h02);
    Evt_Ready = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      chk("bp_drain_code", {28'd0, Evt_Code}, 32'(j));
      chk("bp_drain_valid", {31'd0, Evt_Valid}, 32'd1);
      tick();
    end
    chk("bp_empty", {31'd0, Evt_Valid}, 32'd0);

    // Clear, then saturate the error counter; Clr with a pulse yields 1.
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    chk("clr_dropc", {24'd0, Drop_Count}, 32'd0);
    chk("clr_ovf",   {31'd0, Overflow},   32'd0);
    chk("clr_errc",  {24'd0, Error_Count}, 32'd0);
    Config_Error = 4'hE;
    Error_Valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
    end
    chk("sat_errc",  {24'd0, Error_Count}, 32'd255);
    chk("sat_dropc", {24'd0, Drop_Count},  32'd0);
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    Error_Valid = 1'b0;
    chk("clr_inc_errc", {24'd0, Error_Count}, 32'd1);
    Config_Status = 4'h0;
    for (int i = 0; i < 6; i++) begin
      tick();
    end
    chk("sat_drained", {31'd0, Evt_Valid}, 32'd0);

    // Asynchronous reset in the middle of buffered traffic.
    Evt_Ready = 1'b0;
    Config_Error = 4'h4;
    Error_Valid = 1'b1;
    tick();
    Error_Valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      Config_Notification = 4'(i);
      Config_Notification_Valid = 1'b1;
      tick();
      Config_Notification_Valid = 1'b0;
      tick();
    end
    tick();
    chk("mid_valid_pre", {31'd0, Evt_Valid}, 32'd1);
    chk("mid_errc_pre",  {24'd0, Error_Count}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, Evt_Valid}, 32'd0);
    chk("mid_rst_errc",  {24'd0, Error_Count}, 32'd0);
    chk("mid_rst_dropc", {24'd0, Drop_Count},  32'd0);
    chk("mid_rst_ovf",   {31'd0, Overflow},    32'd0);
    #9;
    rst_n = 1'b1;
    tick();
    Evt_Ready = 1'b1;
    chk("mid_after_valid", {31'd0, Evt_Valid}, 32'd0);
    VGA_Notification = 4'h6;
    Data_VGA = 8'h77;
    VGA_Notification_Valid = 1'b1;
    tick();
    VGA_Notification_Valid = 1'b0;
    chk("mid_lat1", {31'd0, Evt_Valid}, 32'd0);
    tick();
    chk_evt("mid_vga", 2'd2, 4'h6, 8'h77);
    tick();
    chk("mid_vga_gone", {31'd0, Evt_Valid}, 32'd0);

    // Nonzero status held through reset produces exactly one status event.
    #2;
    Config_Status = 4'h7;
    rst_n = 1'b0;
    #10;
    rst_n = 1'b1;
    tick();
    chk("sts_lat1", {31'd0, Evt_Valid}, 32'd0);
    tick();
    chk_evt("sts", 2'd3, 4'h7, 8'h07);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sts_norepeat", {31'd0, Evt_Valid}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cm_event_sink.md
Name: cm_event_sink

Overview:
Receiving end of the CM output interface. It samples Config_Status, Config_Notification, Config_Error and VGA_Notification/Data_VGA from the configuration module. It converts every valid pulse and every status change into a tagged event, buffers the events in a FIFO, and presents them to a host/scoreboard port using a valid/ready handshake. It also keeps a saturating error counter, a saturating drop counter and a sticky overflow flag.

Parameters:
CONFIG_STATUS_WIDTH, 4, width of Config_Status
CONFIG_NOTIFICATION_WIDTH, 4, width of Config_Notification
CONFIG_ERROR_WIDTH, 4, width of Config_Error
VGA_NOTIFICATION_WIDTH, 4, width of VGA_Notification
DATA_WIDTH, 8, width of Data_VGA and Evt_Data
FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2)
CODE_W, max of the four widths above, width of Evt_Code (derived)

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  asynchronous, active-low reset
Config_Status  in  CONFIG_STATUS_WIDTH  CM status level
Config_Notification  in  CONFIG_NOTIFICATION_WIDTH  notification code
Config_Notification_Valid  in  1  qualifies Config_Notification, one cycle per event
Config_Error  in  CONFIG_ERROR_WIDTH  error code
Error_Valid  in  1  qualifies Config_Error
VGA_Notification  in  VGA_NOTIFICATION_WIDTH  VGA notification code
VGA_Notification_Valid  in  1  qualifies VGA_Notification and Data_VGA
Data_VGA  in  DATA_WIDTH  VGA data, sampled with VGA_Notification_Valid
Evt_Valid  out  1  FIFO head valid
Evt_Ready  in  1  consumer accepts the head
Evt_Tag  out  2  0=error, 1=config notification, 2=VGA notification, 3=status change
Evt_Code  out  CODE_W  event code, zero-extended
Evt_Data  out  DATA_WIDTH  Data_VGA for tag 2; Config_Status, zero-extended, for the other tags
Clr  in  1  synchronous pulse: clears the counters and Overflow
Error_Count  out  8  saturating count of sampled Error_Valid pulses
Drop_Count  out  8  saturating count of dropped events
Overflow  out  1  sticky flag, set on any drop

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, so Evt_Valid=0 and Evt_Tag/Evt_Code/Evt_Data=0. All pending slots are cleared. Error_Count=0, Drop_Count=0, Overflow=0. The previous-status register is 0. Reset mid-operation discards all buffered and pending events.
- Capture: four one-deep pending slots, one per source (ERR, CFG, VGA, STS).
  - On each posedge, a sampled valid loads its slot with code, data and the current Config_Status.
  - STS loads when Config_Status differs from the previous-status register. That register updates every cycle. A nonzero status in the first cycle after reset produces an event.
- Arbitration: each cycle, at most one occupied slot is pushed into the FIFO, in fixed priority ERR > CFG > VGA > STS. A push happens only if the FIFO is not full or a pop happens in the same cycle.
- Slot conflict:
  - A new valid arrives for a slot that is occupied and not being pushed this cycle: the new event is dropped, Drop_Count increments (saturating at 255) and Overflow is set.
  - The slot is being pushed in the same cycle: the new event is accepted into the slot.
- Latency: with an idle block, an input sampled at edge k loads its slot at k and is pushed at k+1. Evt_Valid is high after edge k+1, which is 2 cycles.
- FIFO: show-ahead. The head is on Evt_*, and a pop occurs when Evt_Valid && Evt_Ready.
  - When full, slots hold their contents and are not lost. Only new arrivals to occupied slots are dropped.
  - Simultaneous push and pop at full or at empty is legal. The count is unchanged at full.
  - A push into an empty FIFO is not visible until the next cycle; there is no bypass.
  - Pointers wrap modulo FIFO_DEPTH.
- Evt_* must stay stable while Evt_Valid && !Evt_Ready.
- Error_Count increments on every sampled Error_Valid, including dropped ones, and saturates at 255.
- Clr: Clr and an increment in the same cycle give a result of 1. Clr and a drop in the same cycle give Drop_Count=1 and Overflow=1. Clr does not affect the FIFO or the slots.
- The block never applies backpressure to CM; CM outputs have no ready.

Test Plan:
- Single VGA event: VGA_Notification=4'h5, Data_VGA=8'hA3, 1 cycle, with Evt_Ready=1 -> 2 cycles later Evt_Valid=1, Tag=2, Code=5, Data=A3, for one cycle.
- Simultaneous events: Error_Valid (code 3), Config_Notification_Valid (code 9), VGA_Notification_Valid (code 1) and a status change 0->2, all in one cycle -> events pop in the order Tag 0, 1, 2, 3 on 4 consecutive cycles. Error_Count=1 and Drop_Count=0.
- Backpressure: Evt_Ready=0, 8 CFG events spaced 2 cycles apart, then 2 more -> FIFO holds 8, the slot holds event 9, event 10 is dropped. Drop_Count=1, Overflow=1. After Evt_Ready=1, 9 events drain in order.
- Saturation and Clr: 300 Error_Valid pulses -> Error_Count=255. Clr together with an Error_Valid -> Error_Count=1.
- Reset mid-operation: 5 events buffered, then rst_n low for 1 cycle asynchronously between edges -> Evt_Valid=0 and counters=0 immediately. Next event latency is 2 cycles.
- Status first cycle after reset: Config_Status=4'h7 held through reset -> one Tag 3, Code 7 event and no repeats while the status is stable.
